// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine controller and its phase timer.
package wm_pkg;

  // Main controller state encodings.
  typedef enum logic [2:0] {
    CTRL_IDLE,
    CTRL_FILL,
    CTRL_WASH,
    CTRL_DRAIN,
    CTRL_RINSE,
    CTRL_SPIN
  } ctrl_state_e;

  // Phase timer states.
  typedef enum logic [2:0] {
    T_IDLE,
    T_RUN_CYCLE,
    T_RUN_SPIN,
    T_EXP_CYCLE,
    T_EXP_SPIN
  } timer_state_e;

  // Wash program codes; code 3 is treated like HEAVY.
  localparam logic [1:0] PROG_LIGHT  = 2'd0;
  localparam logic [1:0] PROG_NORMAL = 2'd1;
  localparam logic [1:0] PROG_HEAVY  = 2'd2;

  // True when a non-negative value is representable in the given bit width.
  function automatic bit fits_width(input int value, input int width);
    if (value < 0) return 1'b0;
    if (width >= 31) return 1'b1;
    return (value >> width) == 0;
  endfunction

endpackage

// File: rtl/wm_tick_prescaler.sv
// Divides clk into single-cycle ticks every PRESCALE enabled cycles.
// clr zeroes the phase so each timed phase starts on a full tick period.
module wm_tick_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;
  logic          at_last;

  assign at_last = (pcnt == LAST);
  assign tick    = en & ~clr & at_last;

  // Count enabled cycles, wrapping on the last one of each tick period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      if (at_last) pcnt <= '0;
      else         pcnt <= pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/wm_phase_timer.sv
// Agitation and spin phase timer feeding the washing-machine controller.
//
// state        | meaning
// -------------+------------------------------------------------------
// T_IDLE       | no phase timed, count 0, waiting for cycle_run/spin_run
// T_RUN_CYCLE  | timing wash or rinse agitation
// T_RUN_SPIN   | timing spin
// T_EXP_CYCLE  | agitation time expired, cycle_timeout held until run drops
// T_EXP_SPIN   | spin time expired, spin_timeout held until run drops
//
// All outputs are registered and decoded alongside the state update, so the
// controller can react combinationally to them without forming a loop.
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int PRESCALE    = 1000,
  parameter int CNT_W       = 16,
  parameter int WASH_LIGHT  = 20,
  parameter int WASH_NORMAL = 40,
  parameter int WASH_HEAVY  = 60,
  parameter int RINSE_TICKS = 15,
  parameter int SPIN_TICKS  = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       prog,
  input  logic             cycle_run,
  input  logic             rinse_sel,
  input  logic             spin_run,
  input  logic             pause,
  output logic             cycle_timeout,
  output logic             spin_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  localparam bit TICKS_FIT = fits_width(WASH_LIGHT, CNT_W)  &&
                             fits_width(WASH_NORMAL, CNT_W) &&
                             fits_width(WASH_HEAVY, CNT_W)  &&
                             fits_width(RINSE_TICKS, CNT_W) &&
                             fits_width(SPIN_TICKS, CNT_W);

  if (!TICKS_FIT) begin : g_bad_width
    $error("wm_phase_timer: a tick parameter does not fit in CNT_W bits");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("wm_phase_timer: PRESCALE must be at least 1");
  end

  // A zero duration would never expire through the count==1 path, so it is
  // promoted to a single tick.
  localparam logic [CNT_W-1:0] LD_LIGHT  = CNT_W'((WASH_LIGHT  < 1) ? 1 : WASH_LIGHT);
  localparam logic [CNT_W-1:0] LD_NORMAL = CNT_W'((WASH_NORMAL < 1) ? 1 : WASH_NORMAL);
  localparam logic [CNT_W-1:0] LD_HEAVY  = CNT_W'((WASH_HEAVY  < 1) ? 1 : WASH_HEAVY);
  localparam logic [CNT_W-1:0] LD_RINSE  = CNT_W'((RINSE_TICKS < 1) ? 1 : RINSE_TICKS);
  localparam logic [CNT_W-1:0] LD_SPIN   = CNT_W'((SPIN_TICKS  < 1) ? 1 : SPIN_TICKS);

  timer_state_e     state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cycle_load;
  logic             running;
  logic             prs_en;
  logic             prs_clr;
  logic             tick;

  // Agitation duration: rinse overrides the program selection.
  always_comb begin
    cycle_load = LD_HEAVY;
    if (rinse_sel) begin
      cycle_load = LD_RINSE;
    end else begin
      case (prog)
        PROG_LIGHT:  cycle_load = LD_LIGHT;
        PROG_NORMAL: cycle_load = LD_NORMAL;
        PROG_HEAVY:  cycle_load = LD_HEAVY;
        default:     cycle_load = LD_HEAVY;
      endcase
    end
  end

  assign running = ((state == T_RUN_CYCLE) && cycle_run) ||
                   ((state == T_RUN_SPIN)  && spin_run);
  assign prs_en  = running & ~pause;
  assign prs_clr = (state == T_IDLE);

  wm_tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (prs_clr),
    .en   (prs_en),
    .tick (tick)
  );

  assign remaining = count;

  // Phase sequencing, tick down-count and registered output decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= T_IDLE;
      count         <= '0;
      busy          <= 1'b0;
      cycle_timeout <= 1'b0;
      spin_timeout  <= 1'b0;
    end else begin
      case (state)
        T_IDLE: begin
          cycle_timeout <= 1'b0;
          spin_timeout  <= 1'b0;
          if (cycle_run) begin
            state <= T_RUN_CYCLE;
            count <= cycle_load;
            busy  <= 1'b1;
          end else if (spin_run) begin
            state <= T_RUN_SPIN;
            count <= LD_SPIN;
            busy  <= 1'b1;
          end else begin
            count <= '0;
            busy  <= 1'b0;
          end
        end
        T_RUN_CYCLE: begin
          if (!cycle_run) begin
            state <= T_IDLE;
            count <= '0;
            busy  <= 1'b0;
          end else if (tick) begin
            if (count == CNT_W'(1)) begin
              state         <= T_EXP_CYCLE;
              count         <= '0;
              busy          <= 1'b0;
              cycle_timeout <= 1'b1;
            end else begin
              count <= count - CNT_W'(1);
            end
          end
        end
        T_RUN_SPIN: begin
          if (!spin_run) begin
            state <= T_IDLE;
            count <= '0;
            busy  <= 1'b0;
          end else if (tick) begin
            if (count == CNT_W'(1)) begin
              state        <= T_EXP_SPIN;
              count        <= '0;
              busy         <= 1'b0;
              spin_timeout <= 1'b1;
            end else begin
              count <= count - CNT_W'(1);
            end
          end
        end
        T_EXP_CYCLE: begin
          if (!cycle_run) begin
            state         <= T_IDLE;
            cycle_timeout <= 1'b0;
          end
        end
        T_EXP_SPIN: begin
          if (!spin_run) begin
            state        <= T_IDLE;
            spin_timeout <= 1'b0;
          end
        end
        default: begin
          state         <= T_IDLE;
          count         <= '0;
          busy          <= 1'b0;
          cycle_timeout <= 1'b0;
          spin_timeout  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/wm_phase_timer.md
Name: wm_phase_timer

Overview:
- Timing stage directly upstream of the washing-machine controller FSM.
- Times the wash/rinse agitation phase and the spin phase, and produces the `cycle_timeout` and `spin_timeout` levels the controller consumes.
- Durations are selected per wash program and counted in prescaled ticks.
- Also exposes remaining time for a display stage.

Parameters:
- PRESCALE, 1000, clk cycles per timer tick (>=1)
- CNT_W, 16, width of tick counter and remaining output
- WASH_LIGHT, 20, ticks of soap-wash agitation, program 0
- WASH_NORMAL, 40, ticks of soap-wash agitation, program 1
- WASH_HEAVY, 60, ticks of soap-wash agitation, programs 2 and 3
- RINSE_TICKS, 15, ticks of rinse agitation, all programs
- SPIN_TICKS, 25, ticks of spin, all programs

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- prog  input  2  wash program select, sampled at cycle load
- cycle_run  input  1  agitation phase active (driven from controller motor_on)
- rinse_sel  input  1  1 = current cycle is rinse (controller water_wash), sampled at load
- spin_run  input  1  spin phase active
- pause  input  1  freeze counting (door-open/user pause), state retained
- cycle_timeout  output  1  registered; high while agitation time expired
- spin_timeout  output  1  registered; high while spin time expired
- busy  output  1  registered; high in RUN_CYCLE or RUN_SPIN
- remaining  output  CNT_W  ticks left in current phase, 0 when idle

Behaviour:
- Reset (async, active-high):
  - state=IDLE, count=0, prescaler=0.
  - All outputs 0.
  - Releasing reset mid-operation restarts from IDLE; no timeout is generated.
- States: IDLE, RUN_CYCLE, RUN_SPIN, EXP_CYCLE, EXP_SPIN.
- IDLE:
  - If cycle_run=1: load count, clear prescaler, go to RUN_CYCLE at the next edge.
  - Count loaded = RINSE_TICKS if rinse_sel=1; otherwise the wash ticks for prog (0→LIGHT, 1→NORMAL, 2/3→HEAVY).
  - Else if spin_run=1: load SPIN_TICKS, go to RUN_SPIN.
  - If both are high, cycle_run has priority.
  - A loaded value of 0 is forced to 1.
- RUN_x:
  - Prescaler increments each clk when pause=0.
  - When prescaler==PRESCALE-1 it wraps to 0 and a tick is issued.
  - On a tick, count decrements.
  - When a tick hits with count==1, count becomes 0 and the state goes to EXP_x at the same edge.
  - Load-to-expiry latency with no pause = loaded_ticks*PRESCALE clk cycles exactly.
- pause=1:
  - Prescaler and count hold; state unchanged.
  - Pause does not suppress abort or expiry already registered.
- Abort: if the run input of the current phase goes low in RUN_x, return to IDLE next edge, count=0, no timeout pulse.
- EXP_CYCLE:
  - cycle_timeout=1.
  - Stays until cycle_run=0, then IDLE.
  - Because the controller drops motor_on combinationally on timeout, timeout normally lasts 1 cycle.
- EXP_SPIN: spin_timeout=1; stays until spin_run=0, then IDLE.
- No back-to-back reload: after any EXP state the block must pass through IDLE (>=1 cycle) before a new load.
- Outputs are decoded registered from state; there is no combinational path from inputs to outputs, which avoids loops with the controller.
- remaining equals count; updated the same edge as count.
- Width rule: all tick parameters must be < 2^CNT_W. This is checked by an elaboration-time assertion.

Decomposition:
- Shared package wm_pkg:
  - Controller state encodings.
  - Timer state enum (IDLE..EXP_SPIN).
  - Program codes PROG_LIGHT/NORMAL/HEAVY.
- One natural sub-module: wm_tick_prescaler.
  - Ports: clk, reset, clr, en, tick.
  - Generates the tick with synchronous clear on phase load.
- Duration mux and FSM stay in wm_phase_timer.

Test Plan:
Use PRESCALE=4, WASH_LIGHT=3, WASH_NORMAL=5, RINSE_TICKS=2, SPIN_TICKS=4.
1. Normal wash: prog=1, rinse_sel=0, raise cycle_run → busy=1 next edge, remaining=5; cycle_timeout rises exactly 20 clks after load; drop cycle_run that cycle → timeout=0, IDLE one cycle later.
2. Rinse, then spin: rinse_sel=1 → timeout after 8 clks. After IDLE, raise spin_run → spin_timeout after 16 clks; cycle_timeout never asserts.
3. Pause: prog=0, assert pause for 10 clks mid-run → cycle_timeout delayed to 12+10=22 clks after load; remaining frozen during pause.
4. Abort: drop cycle_run after 6 clks → IDLE, remaining=0, no timeout ever. Simultaneous cycle_run=spin_run=1 → RUN_CYCLE chosen.
5. Reset mid-RUN_SPIN: assert reset asynchronously → all outputs 0 immediately; after release with spin_run still 1 → fresh load of 4 ticks.
6. Program 3 and held expiry: prog=3 loads WASH_HEAVY; holding cycle_run high after expiry keeps cycle_timeout=1 until it drops.
